// File: rtl/cat_pkg.sv
// rtl/cat_pkg.sv - shared state encoding and attribute bit positions for the cat scanner
package cat_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } cat_state_t;

    localparam int CAT_BLACK       = 3;
    localparam int CAT_RED         = 2;
    localparam int CAT_STERILIZED  = 1;
    localparam int CAT_MALE        = 0;
    localparam int CAT_NUM_VECTORS = 16;

endpackage

// File: rtl/cat_selector.sv
// rtl/cat_selector.sv - downstream selector judging one attribute vector at a time
module cat_selector (
    input  logic IsBlack,
    input  logic IsRed,
    input  logic IsSterilized,
    input  logic IsMale,
    output logic IsMyCat
);

    assign IsMyCat = IsSterilized & ~IsMale & (IsBlack | IsRed);

endmodule

// File: rtl/cat_scanner.sv
// rtl/cat_scanner.sv - walks all 16 attribute vectors and records the selector verdicts
module cat_scanner
    import cat_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    output logic        IsBlack,
    output logic        IsRed,
    output logic        IsSterilized,
    output logic        IsMale,
    input  logic        IsMyCat,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] MatchMask,
    output logic [4:0]  MatchCount
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_INDEX  = 4'(CAT_NUM_VECTORS - 1);

    cat_state_t state;
    logic [3:0] index;
    logic [3:0] settle_cnt;
    logic [3:0] index_inc;

    assign index_inc = index + 4'd1;

    // Attribute outputs are registered and loaded on the edge entering DRIVE,
    // so they already show the new index during the first settle cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            index        <= '0;
            settle_cnt   <= '0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            IsBlack      <= 1'b0;
            IsRed        <= 1'b0;
            IsSterilized <= 1'b0;
            IsMale       <= 1'b0;
            MatchMask    <= '0;
            MatchCount   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        MatchMask    <= '0;
                        MatchCount   <= '0;
                        index        <= '0;
                        settle_cnt   <= '0;
                        Busy         <= 1'b1;
                        IsBlack      <= 1'b0;
                        IsRed        <= 1'b0;
                        IsSterilized <= 1'b0;
                        IsMale       <= 1'b0;
                        state        <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    MatchMask[index] <= IsMyCat;
                    if (IsMyCat) begin
                        MatchCount <= MatchCount + 5'd1;
                    end
                    if (index == LAST_INDEX) begin
                        Busy         <= 1'b0;
                        Done         <= 1'b1;
                        IsBlack      <= 1'b0;
                        IsRed        <= 1'b0;
                        IsSterilized <= 1'b0;
                        IsMale       <= 1'b0;
                        state        <= DONE;
                    end else begin
                        index        <= index_inc;
                        IsBlack      <= index_inc[CAT_BLACK];
                        IsRed        <= index_inc[CAT_RED];
                        IsSterilized <= index_inc[CAT_STERILIZED];
                        IsMale       <= index_inc[CAT_MALE];
                        state        <= DRIVE;
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cat_scanner.sv
// tb/tb_cat_scanner.sv - directed bench for cat_scanner driving a cat_selector
module tb_cat_scanner;

    logic        clk;
    logic        reset;
    logic        start;
    logic        start3;
    logic        is_black, is_red, is_sterilized, is_male, is_my_cat;
    logic        busy, done;
    logic [15:0] match_mask;
    logic [4:0]  match_count;
    logic        is_black3, is_red3, is_sterilized3, is_male3;
    logic        busy3, done3;
    logic [15:0] match_mask3;
    logic [4:0]  match_count3;
    logic        const_match;

    int n_cmp;
    int n_bad;

    logic [3:0] attrs;
    logic [3:0] attrs3;
    assign attrs  = {is_black, is_red, is_sterilized, is_male};
    assign attrs3 = {is_black3, is_red3, is_sterilized3, is_male3};

    cat_scanner #(.SETTLE_CYCLES(1)) u_dut (
        .Clk(clk), .Reset(reset), .Start(start),
        .IsBlack(is_black), .IsRed(is_red), .IsSterilized(is_sterilized), .IsMale(is_male),
        .IsMyCat(is_my_cat), .Busy(busy), .Done(done),
        .MatchMask(match_mask), .MatchCount(match_count)
    );

    cat_selector u_sel (
        .IsBlack(is_black), .IsRed(is_red), .IsSterilized(is_sterilized), .IsMale(is_male),
        .IsMyCat(is_my_cat)
    );

    cat_scanner #(.SETTLE_CYCLES(3)) u_dut3 (
        .Clk(clk), .Reset(reset), .Start(start3),
        .IsBlack(is_black3), .IsRed(is_red3), .IsSterilized(is_sterilized3), .IsMale(is_male3),
        .IsMyCat(const_match), .Busy(busy3), .Done(done3),
        .MatchMask(match_mask3), .MatchCount(match_count3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({busy, done, attrs, match_mask, match_count} !== 27'd0) begin
            n_bad++;
            $display("FAIL reset_held: got busy=%b done=%b attrs=%h mask=%h count=%0d, want all 0",
                     busy, done, attrs, match_mask, match_count);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if ({busy, done, attrs, match_mask, match_count} !== 27'd0) begin
            n_bad++;
            $display("FAIL reset_released: got busy=%b done=%b attrs=%h mask=%h count=%0d, want all 0",
                     busy, done, attrs, match_mask, match_count);
        end
        n_cmp++;
        if ({busy3, done3, attrs3, match_mask3, match_count3} !== 27'd0) begin
            n_bad++;
            $display("FAIL reset_dut3: got busy=%b done=%b attrs=%h mask=%h count=%0d, want all 0",
                     busy3, done3, attrs3, match_mask3, match_count3);
        end
    endtask

    task automatic test_full_scan();
        logic [5:0] exp;
        logic [3:0] idx;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            idx = 4'((c - 1) / 2);
            if (c <= 32)       exp = {1'b1, 1'b0, idx};
            else if (c == 33)  exp = {1'b0, 1'b1, 4'd0};
            else               exp = 6'd0;
            n_cmp++;
            if ({busy, done, attrs} !== exp) begin
                n_bad++;
                $display("FAIL full_scan_cycle%0d: got busy/done/attrs=%b, want %b",
                         c, {busy, done, attrs}, exp);
            end
            tick();
        end
        n_cmp++;
        if (match_mask !== 16'h4440) begin
            n_bad++;
            $display("FAIL full_scan_mask: got %h, want 4440", match_mask);
        end
        n_cmp++;
        if (match_count !== 5'd3) begin
            n_bad++;
            $display("FAIL full_scan_count: got %0d, want 3", match_count);
        end
    endtask

    task automatic test_busy_start();
        int first_done;
        int n_done;
        first_done = -1;
        n_done     = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            start = (c == 10);
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
            tick();
        end
        start = 1'b0;
        n_cmp++;
        if (first_done != 33) begin
            n_bad++;
            $display("FAIL busy_start_done_cycle: got %0d, want 33", first_done);
        end
        n_cmp++;
        if (n_done != 1) begin
            n_bad++;
            $display("FAIL busy_start_done_pulses: got %0d, want 1", n_done);
        end
        n_cmp++;
        if ({match_mask, match_count} !== {16'h4440, 5'd3}) begin
            n_bad++;
            $display("FAIL busy_start_result: got mask=%h count=%0d, want 4440/3",
                     match_mask, match_count);
        end
    endtask

    task automatic test_saturation();
        int first_done;
        int n_done;
        first_done = -1;
        n_done     = 0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int c = 1; c <= 90; c++) begin
            if (c == 64) begin
                n_cmp++;
                if ({busy3, done3, attrs3} !== {1'b1, 1'b0, 4'hF}) begin
                    n_bad++;
                    $display("FAIL saturation_last_sample: got busy/done/attrs=%b, want 101111",
                             {busy3, done3, attrs3});
                end
            end
            if (done3) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
            tick();
        end
        n_cmp++;
        if (first_done != 65 || n_done != 1) begin
            n_bad++;
            $display("FAIL saturation_done: got cycle %0d pulses %0d, want cycle 65 pulses 1",
                     first_done, n_done);
        end
        n_cmp++;
        if (match_mask3 !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL saturation_mask: got %h, want ffff", match_mask3);
        end
        n_cmp++;
        if (match_count3 !== 5'd16) begin
            n_bad++;
            $display("FAIL saturation_count: got %0d, want 16", match_count3);
        end
    endtask

    task automatic test_reset_mid_scan();
        int n_done;
        int n_busy;
        n_done = 0;
        n_busy = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_scan_busy_before: got %b, want 1", busy);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, attrs, match_mask, match_count} !== 27'd0) begin
            n_bad++;
            $display("FAIL mid_scan_async_clear: got busy=%b done=%b attrs=%h mask=%h count=%0d, want all 0",
                     busy, done, attrs, match_mask, match_count);
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) n_done++;
            if (busy) n_busy++;
            tick();
        end
        n_cmp++;
        if (n_done != 0 || n_busy != 0) begin
            n_bad++;
            $display("FAIL mid_scan_no_done: got done cycles %0d busy cycles %0d, want 0 and 0",
                     n_done, n_busy);
        end
    endtask

    task automatic test_back_to_back();
        int first_done;
        first_done = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 33; c++) tick();
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_first_done: got %b at cycle 33, want 1", done);
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({busy, match_mask, match_count} !== {1'b1, 16'h0, 5'd0}) begin
            n_bad++;
            $display("FAIL b2b_cleared: got busy=%b mask=%h count=%0d, want 1/0000/0",
                     busy, match_mask, match_count);
        end
        for (int c = 35; c <= 75; c++) begin
            if (done && first_done < 0) first_done = c;
            tick();
        end
        n_cmp++;
        if (first_done != 67) begin
            n_bad++;
            $display("FAIL b2b_second_done: got cycle %0d, want 67", first_done);
        end
        n_cmp++;
        if ({match_mask, match_count} !== {16'h4440, 5'd3}) begin
            n_bad++;
            $display("FAIL b2b_result: got mask=%h count=%0d, want 4440/3", match_mask, match_count);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        reset       = 1'b1;
        start       = 1'b0;
        start3      = 1'b0;
        const_match = 1'b1;
        #1;
        test_reset();
        test_full_scan();
        test_busy_start();
        test_saturation();
        test_reset_mid_scan();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
